// File: rtl/uart_tx_framer.sv
// UART transmitter fed from an AXI-Stream slave through a small FIFO.
// Runtime prescale, optional parity and a second stop bit, all latched per frame.
`timescale 1ns/1ps
module uart_tx_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic                        txd,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   input  logic [15:0]                 prescale,
   input  logic                        parity_en,
   input  logic                        parity_odd,
   input  logic                        two_stop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [LW-1:0]         level;
   logic                  push;
   logic                  pop;
   logic                  fifo_empty;
   logic                  stop_done;
   logic [DATA_WIDTH-1:0] head;

   state_t                state;
   logic [18:0]           bit_cnt;
   logic [18:0]           frame_reload;
   logic [18:0]           new_reload;
   logic [15:0]           prescale_eff;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BW-1:0]         bit_idx;
   logic                  frame_parity_en;
   logic                  frame_parity_bit;
   logic                  frame_two_stop;
   logic                  second_stop;

   assign fifo_empty    = (level == '0);
   assign s_axis_tready = !rst && (level != FULL_LEVEL);
   assign push          = s_axis_tvalid && s_axis_tready;
   assign head          = mem[rd_ptr];
   assign fifo_level    = level;

   // A frame is loaded from IDLE, or straight out of the final stop bit so frames abut.
   assign stop_done = (state == STOP) && (bit_cnt == '0) && (!frame_two_stop || second_stop);
   assign pop       = !fifo_empty && ((state == IDLE) || stop_done);

   assign prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
   assign new_reload   = {prescale_eff, 3'b000} - 19'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_axis_tdata;
      end
   end

   // Parity is resolved at load time so later config changes cannot reach the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         txd              <= 1'b1;
         busy             <= 1'b0;
         bit_cnt          <= '0;
         frame_reload     <= '0;
         shift_reg        <= '0;
         bit_idx          <= '0;
         frame_parity_en  <= 1'b0;
         frame_parity_bit <= 1'b0;
         frame_two_stop   <= 1'b0;
         second_stop      <= 1'b0;
      end else if (pop) begin
         state            <= START;
         txd              <= 1'b0;
         busy             <= 1'b1;
         bit_cnt          <= new_reload;
         frame_reload     <= new_reload;
         shift_reg        <= head;
         bit_idx          <= '0;
         frame_parity_en  <= parity_en;
         frame_parity_bit <= (^head) ^ parity_odd;
         frame_two_stop   <= two_stop;
         second_stop      <= 1'b0;
      end else if (state != IDLE && bit_cnt != '0) begin
         bit_cnt <= bit_cnt - 19'd1;
      end else begin
         bit_cnt <= frame_reload;
         case (state)
            START: begin
               state     <= DATA;
               txd       <= shift_reg[0];
               shift_reg <= shift_reg >> 1;
               bit_idx   <= '0;
            end
            DATA: begin
               if (bit_idx == LAST_BIT) begin
                  if (frame_parity_en) begin
                     state <= PARITY;
                     txd   <= frame_parity_bit;
                  end else begin
                     state <= STOP;
                     txd   <= 1'b1;
                  end
               end else begin
                  txd       <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_idx   <= bit_idx + BW'(1);
               end
            end
            PARITY: begin
               state <= STOP;
               txd   <= 1'b1;
            end
            STOP: begin
               if (frame_two_stop && !second_stop) begin
                  second_stop <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  txd   <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets payload bits per frame.
REQ-002 Parameter FIFO_DEPTH, default 4, sets input FIFO entries; power of two, minimum 2.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset; one clock, reset synchronous and active-high.
REQ-005 Port s_axis_tdata, input, DATA_WIDTH: byte to transmit.
REQ-006 Port s_axis_tvalid, input, 1: tdata valid.
REQ-007 Port s_axis_tready, output, 1: equals !fifo_full; forced 0 while rst high.
REQ-008 Port txd, output, 1: registered serial line; idle high.
REQ-009 Port busy, output, 1: registered; high while FSM is not IDLE.
REQ-010 Port fifo_level, output, $clog2(FIFO_DEPTH)+1: queued entries, excluding the frame in flight.
REQ-011 Port prescale, input, 16: bit period = 8*max(prescale,1) clk cycles.
REQ-012 Port parity_en, input, 1: append parity bit after data.
REQ-013 Port parity_odd, input, 1: 1 = odd parity, 0 = even parity.
REQ-014 Port two_stop, input, 1: 1 = two stop bits, 0 = one stop bit.

Function
REQ-015 Transfer occurs on an edge where s_axis_tvalid && s_axis_tready; data is written to the FIFO tail.
REQ-016 FIFO is full at fifo_level == FIFO_DEPTH; push and pop in the same cycle leave fifo_level unchanged.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE with FIFO non-empty: pop head into shift register; capture prescale, parity_en, parity_odd and two_stop into frame-local registers; drive txd=0; enter START.
REQ-019 Config inputs changing mid-frame do not affect the frame in flight.
REQ-020 Each state holds txd for exactly one bit period, counted by an internal 19-bit down-counter loaded with 8*max(prescale,1)-1.
REQ-021 START -> DATA: DATA_WIDTH bits sent LSB first, one per bit period.
REQ-022 After the last data bit: enter PARITY if parity_en was captured, otherwise enter STOP.
REQ-023 Parity bit = XOR of the data bits, inverted when parity_odd was captured.
REQ-024 STOP drives txd=1 for one bit period, or two bit periods when two_stop was captured.
REQ-025 At STOP end with FIFO non-empty: pop and drive START on the same edge, so no idle gap between frames.
REQ-026 At STOP end with FIFO empty: return to IDLE; txd stays 1; busy falls on that edge.
REQ-027 Latency: FIFO empty, FSM IDLE, word accepted at edge E -> txd low and busy high from edge E+1.
REQ-028 Frame length in clk cycles = 8*max(prescale,1)*(2 + DATA_WIDTH + parity_en + two_stop).
REQ-029 tvalid asserted while tready is low: no write; data is held by the source per AXI-Stream rules.

Reset
REQ-030 When rst is high at a clock edge, on that edge: txd=1, busy=0, fifo_level=0, FIFO pointers cleared, FSM=IDLE, counters cleared.
REQ-031 Reset mid-frame aborts the frame: txd returns high on that edge and queued data is discarded.
REQ-032 No transfer is accepted on any edge where rst is high.

Verification
REQ-033 prescale=1, parity_en=0, two_stop=0, send 0xA5 -> txd low 8 cycles; then 1,0,1,0,0,1,0,1 at 8 cycles each; then high 8 cycles; busy high exactly 80 cycles.
REQ-034 prescale=2, parity_en=1, parity_odd=0, send 0x07 -> parity bit 1 for 16 cycles; frame 176 cycles. Repeat with parity_odd=1 -> parity bit 0.
REQ-035 prescale=1, tvalid held high with 6 words -> 5 accepted back-to-back (1 in flight plus 4 queued); tready low until the first frame ends; frames contiguous with no idle cycles between them.
REQ-036 prescale=0 with two_stop=1, send 0x00 -> bit period 8 cycles, stop high 16 cycles, frame 88 cycles.
REQ-037 Assert rst for 1 cycle at cycle 30 of a frame with 2 words queued -> next edge: txd=1, busy=0, fifo_level=0, tready=1; no further frame emitted.
REQ-038 Change prescale from 1 to 4 mid-frame -> current frame keeps 8-cycle bits; next frame uses 32-cycle bits.
